layer_serializer: RTL and testbench

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer.sv | 92 +++++++++
 tb/tb_layer_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between network layers: captures NN neuron words at once
// and replays them one per cycle as the next layer's x_valid/x_in stream.
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int CW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CW-1:0]           r_count;
    logic [NN*dataWidth-1:0] r_buffer;
    logic                    w_lastWord;
    logic                    w_unusedValid;

    // Only lane 0 qualifies a capture; the other valid bits are deliberately ignored.
    assign w_unusedValid = &{1'b0, in_valid};
    assign w_lastWord    = (r_count == CW'(NN - 1));
    assign busy          = (r_state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid[0]) w_nextState = SHIFT;
            SHIFT:   if (w_lastWord) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A capture request seen while shifting (including the last-word edge) is dropped
    // and latched as a sticky overrun; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buffer  <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    if (in_valid[0]) begin
                        r_buffer <= in_data;
                        r_count  <= '0;
                    end
                end
                SHIFT: begin
                    out_data  <= r_buffer[dataWidth-1:0];
                    out_valid <= 1'b1;
                    r_buffer  <= r_buffer >> dataWidth;
                    r_count   <= r_count + CW'(1);
                    done      <= w_lastWord;
                    if (in_valid[0]) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Randomized and directed bench for layer_serializer, checked against a queue-based
// model; a second NN=1, 8-bit instance covers the single-word boundary case.
module tb_layer_serializer;

    localparam int NN = 30;
    localparam int DW = 16;

    logic             clk;
    logic             rst;
    logic [NN-1:0]    inValid;
    logic [NN*DW-1:0] inData;
    logic             outValid;
    logic [DW-1:0]    outData;
    logic             busy;
    logic             done;
    logic             overrun;

    logic             inValid1;
    logic [7:0]       inData1;
    logic             outValid1;
    logic [7:0]       outData1;
    logic             busy1;
    logic             done1;
    logic             overrun1;

    int checkCount;
    int passCount;

    logic [DW-1:0] expQ[$];
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expDone;
    logic          expOvr;

    logic          pend1;
    logic [7:0]    word1;
    logic          expValid1;
    logic [7:0]    expData1;
    logic          expDone1;
    logic          expOvr1;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
        .out_valid(outValid), .out_data(outData), .busy(busy),
        .done(done), .overrun(overrun)
    );

    layer_serializer #(.NN(1), .dataWidth(8)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_data(inData1),
        .out_valid(outValid1), .out_data(outData1), .busy(busy1),
        .done(done1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        expValid = 1'b0;
        expData  = '0;
        expDone  = 1'b0;
        expOvr   = 1'b0;
        pend1     = 1'b0;
        word1     = '0;
        expValid1 = 1'b0;
        expData1  = '0;
        expDone1  = 1'b0;
        expOvr1   = 1'b0;
    endtask

    // One rising edge of the model: a pending word is emitted, otherwise a capture may start.
    task automatic modelEdge(input logic v0, input logic [NN*DW-1:0] d);
        if (expQ.size() != 0) begin
            expData  = expQ.pop_front();
            expValid = 1'b1;
            expDone  = (expQ.size() == 0);
            if (v0) expOvr = 1'b1;
        end else begin
            expValid = 1'b0;
            expDone  = 1'b0;
            if (v0) begin
                for (int i = 0; i < NN; i++) expQ.push_back(d[i*DW +: DW]);
            end
        end
    endtask

    task automatic checkMain();
        checkOutput("out_valid", 32'(outValid), 32'(expValid));
        checkOutput("out_data", 32'(outData), 32'(expData));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
        checkOutput("overrun", 32'(overrun), 32'(expOvr));
    endtask

    task automatic checkSmall();
        checkOutput("small out_valid", 32'(outValid1), 32'(expValid1));
        checkOutput("small out_data", 32'(outData1), 32'(expData1));
        checkOutput("small done", 32'(done1), 32'(expDone1));
        checkOutput("small busy", 32'(busy1), 32'(pend1));
        checkOutput("small overrun", 32'(overrun1), 32'(expOvr1));
    endtask

    task automatic applyStimulus(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
        inValid = v;
        inData  = d;
        @(posedge clk);
        modelEdge(v[0], d);
        @(negedge clk);
        checkMain();
    endtask

    task automatic applyStimulusSmall(input logic v, input logic [7:0] d);
        inValid1 = v;
        inData1  = d;
        @(posedge clk);
        if (pend1) begin
            expValid1 = 1'b1;
            expData1  = word1;
            expDone1  = 1'b1;
            pend1     = 1'b0;
            if (v) expOvr1 = 1'b1;
        end else begin
            expValid1 = 1'b0;
            expDone1  = 1'b0;
            if (v) begin
                pend1 = 1'b1;
                word1 = d;
            end
        end
        @(negedge clk);
        checkSmall();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, '0);
    endtask

    // Asserted between edges so the asynchronous clear is observed before any clock.
    task automatic midReset();
        rst = 1'b1;
        #1;
        resetModel();
        checkMain();
        checkSmall();
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [NN*DW-1:0] rampData(input logic [DW-1:0] base);
        logic [NN*DW-1:0] d;
        for (int i = 0; i < NN; i++) d[i*DW +: DW] = base + DW'(i);
        return d;
    endfunction

    function automatic logic [NN*DW-1:0] randData();
        logic [NN*DW-1:0] d;
        for (int i = 0; i < NN; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        logic [NN-1:0] v;
        checkCount = 0;
        passCount  = 0;
        rst      = 1'b1;
        inValid  = '0;
        inData   = '0;
        inValid1 = 1'b0;
        inData1  = '0;
        resetModel();
        @(negedge clk);
        @(negedge clk);
        checkMain();
        checkSmall();
        rst = 1'b0;

        // Single transfer, then back-to-back at the earliest legal capture edge.
        applyStimulus('1, rampData(16'h0100));
        idle(NN + 2);
        applyStimulus('1, rampData(16'h0100));
        idle(NN);
        applyStimulus('1, rampData(16'h0200));
        idle(NN + 2);
        checkOutput("b2b overrun", 32'(overrun), 32'd0);

        // Capture request on the 10th word edge, then one on the last-word edge.
        applyStimulus('1, rampData(16'h0300));
        idle(9);
        applyStimulus(NN'(1), randData());
        idle(NN - 11);
        applyStimulus(NN'(1), randData());
        idle(3);
        checkOutput("overrun sticky", 32'(overrun), 32'd1);

        // Abort after the 5th word, then a clean transfer.
        applyStimulus('1, rampData(16'h0400));
        idle(5);
        midReset();
        applyStimulus('1, rampData(16'h0500));
        idle(NN + 2);

        for (int k = 0; k < 400; k++) begin
            v    = NN'($urandom);
            v[0] = ($urandom_range(0, 7) == 0);
            applyStimulus(v, randData());
        end
        idle(NN + 2);
        midReset();

        // Single-word instance: one capture, then valid held high continuously.
        applyStimulusSmall(1'b1, 8'hA5);
        applyStimulusSmall(1'b0, 8'h00);
        applyStimulusSmall(1'b0, 8'h00);
        for (int k = 0; k < 4; k++) applyStimulusSmall(1'b1, 8'hA5);
        for (int k = 0; k < 12; k++) applyStimulusSmall(1'b1, 8'($urandom));
        applyStimulusSmall(1'b0, 8'h00);
        applyStimulusSmall(1'b0, 8'h00);
        midReset();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
